vga_pattern_gen: RTL and testbench

- Pixel-stage consumer of the VGA timing counters and syncs; produces the RGB values driven to the DAC pins.
- Selectable test pattern, registered over a 2-stage pipeline; delays hsync/vsync by the same amount so colour and sync stay aligned.
- Runs at the system clock, advances only on the pixel-tick enable from the clock divider.
- Mode changes take effect only at a frame boundary.

---
 rtl/vga_pattern_gen_if.sv | 32 +++
 rtl/vga_pattern_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - timing-in / pixel-out bundle for the VGA pattern stage
// master is the timing side that feeds counts and reads back colour; slave is the pattern stage.
interface vga_pattern_gen_if #(
   parameter int counter_bits = 10,
   parameter int bit_depth    = 4
);
   logic                    pix_en;
   logic [counter_bits-1:0] h_count;
   logic [counter_bits-1:0] v_count;
   logic                    hsync_in;
   logic                    vsync_in;
   logic [1:0]              mode_sel;
   logic                    mode_req;
   logic [bit_depth-1:0]    red;
   logic [bit_depth-1:0]    green;
   logic [bit_depth-1:0]    blue;
   logic                    hsync_out;
   logic                    vsync_out;
   logic                    active_out;
   logic [1:0]              mode_cur;
   logic [7:0]              frame_count;

   modport master (
      output pix_en, h_count, v_count, hsync_in, vsync_in, mode_sel, mode_req,
      input  red, green, blue, hsync_out, vsync_out, active_out, mode_cur, frame_count
   );

   modport slave (
      input  pix_en, h_count, v_count, hsync_in, vsync_in, mode_sel, mode_req,
      output red, green, blue, hsync_out, vsync_out, active_out, mode_cur, frame_count
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - two-stage test-pattern pixel pipeline with frame-aligned mode switching
// Stage 1 registers position and syncs; stage 2 renders colour so syncs and colour leave together.
module vga_pattern_gen #(
   parameter int counter_bits = 10,
   parameter int bit_depth    = 4,
   parameter int h_visible    = 640,
   parameter int v_visible    = 480
) (
   input  logic                clk,
   input  logic                reset,
   vga_pattern_gen_if.slave    bus
);
   localparam int cw = counter_bits;

   localparam logic [1:0] mode_bars    = 2'd0;
   localparam logic [1:0] mode_checker = 2'd1;
   localparam logic [1:0] mode_grad    = 2'd2;
   localparam logic [1:0] mode_box     = 2'd3;

   localparam logic [bit_depth-1:0] c_max  = '1;
   localparam logic [bit_depth-1:0] c_zero = '0;

   localparam logic [cw:0] box_size = (cw+1)'(32);
   localparam logic [cw:0] box_top  = (cw+1)'(224);
   localparam logic [cw:0] box_bot  = (cw+1)'(256);

   typedef enum logic {
      IDLE,
      PENDING
   } mode_state_t;

   // stage 1
   logic [cw-1:0] s1_h;
   logic [cw-1:0] s1_v;
   logic          s1_hs;
   logic          s1_vs;
   logic          s1_active;

   // stage 2 / outputs
   logic [bit_depth-1:0] red_q;
   logic [bit_depth-1:0] green_q;
   logic [bit_depth-1:0] blue_q;
   logic                 hs_q;
   logic                 vs_q;
   logic                 active_q;

   // mode control
   mode_state_t state;
   logic [1:0]  mode_pend;
   logic [1:0]  mode_cur_q;
   logic [7:0]  frame_cnt_q;

   logic in_active;
   logic frame_start;
   logic capture;

   assign in_active   = (bus.h_count < cw'(h_visible)) && (bus.v_count < cw'(v_visible));
   assign frame_start = (bus.h_count == '0) && (bus.v_count == '0);
   assign capture     = bus.pix_en && frame_start;

   // Box geometry is evaluated one bit wider than the counters so box_x+32 never wraps.
   logic [8:0]  box_x;
   logic [cw:0] hx;
   logic [cw:0] vx;
   logic [cw:0] bx;
   logic        in_box;
   logic [2:0]  bar_idx;

   assign box_x   = {frame_cnt_q, 1'b0};
   assign hx      = {1'b0, s1_h};
   assign vx      = {1'b0, s1_v};
   assign bx      = {{(cw-8){1'b0}}, box_x};
   assign in_box  = (hx >= bx) && (hx < bx + box_size) && (vx >= box_top) && (vx < box_bot);
   assign bar_idx = 3'(s1_h / cw'(h_visible / 8));

   logic [bit_depth-1:0] red_n;
   logic [bit_depth-1:0] green_n;
   logic [bit_depth-1:0] blue_n;

   always_comb begin
      red_n   = c_zero;
      green_n = c_zero;
      blue_n  = c_zero;
      if (s1_active) begin
         case (mode_cur_q)
            mode_bars: begin
               red_n   = bar_idx[2] ? c_max : c_zero;
               green_n = bar_idx[1] ? c_max : c_zero;
               blue_n  = bar_idx[0] ? c_max : c_zero;
            end
            mode_checker: begin
               red_n   = (s1_h[5] ^ s1_v[5]) ? c_max : c_zero;
               green_n = (s1_h[5] ^ s1_v[5]) ? c_max : c_zero;
               blue_n  = (s1_h[5] ^ s1_v[5]) ? c_max : c_zero;
            end
            mode_grad: begin
               red_n   = s1_h[cw-1 -: bit_depth];
               green_n = s1_v[cw-2 -: bit_depth];
               blue_n  = frame_cnt_q[bit_depth-1:0];
            end
            mode_box: begin
               red_n   = in_box ? c_max : c_zero;
               green_n = in_box ? c_max : c_zero;
               blue_n  = c_max;
            end
            default: begin
               red_n   = c_zero;
               green_n = c_zero;
               blue_n  = c_zero;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_h      <= '0;
         s1_v      <= '0;
         s1_hs     <= 1'b1;
         s1_vs     <= 1'b1;
         s1_active <= 1'b0;
         red_q     <= '0;
         green_q   <= '0;
         blue_q    <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         active_q  <= 1'b0;
      end else if (bus.pix_en) begin
         s1_h      <= bus.h_count;
         s1_v      <= bus.v_count;
         s1_hs     <= bus.hsync_in;
         s1_vs     <= bus.vsync_in;
         s1_active <= in_active;
         red_q     <= red_n;
         green_q   <= green_n;
         blue_q    <= blue_n;
         hs_q      <= s1_hs;
         vs_q      <= s1_vs;
         active_q  <= s1_active;
      end
   end

   // mode_cur switches on the same tick stage 1 captures (0,0), so that pixel renders in the new mode.
   // A request landing on the capture tick is only latched, never applied in that frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         mode_pend   <= 2'd0;
         mode_cur_q  <= 2'd0;
         frame_cnt_q <= 8'd0;
      end else begin
         if (capture) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
         end
         case (state)
            IDLE: begin
               if (bus.mode_req) begin
                  mode_pend <= bus.mode_sel;
                  state     <= PENDING;
               end
            end
            PENDING: begin
               if (capture) begin
                  mode_cur_q <= mode_pend;
                  state      <= IDLE;
               end
               if (bus.mode_req) begin
                  mode_pend <= bus.mode_sel;
                  state     <= PENDING;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.red         = red_q;
   assign bus.green       = green_q;
   assign bus.blue        = blue_q;
   assign bus.hsync_out   = hs_q;
   assign bus.vsync_out   = vs_q;
   assign bus.active_out  = active_q;
   assign bus.mode_cur    = mode_cur_q;
   assign bus.frame_count = frame_cnt_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed bench for vga_pattern_gen
// Each step drives one pixel tick (pix_en every 4th clk) and checks hand-computed outputs.
module tb_vga_pattern_gen;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vga_pattern_gen_if vif ();

   vga_pattern_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (vif)
   );

   int tests = 0;
   int fails = 0;
   int exp_fc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rgb();
      return 32'({vif.red, vif.green, vif.blue});
   endfunction

   task automatic tick(input int h, input int v, input logic hs, input logic req, input logic [1:0] sel);
      @(negedge clk);
      vif.h_count  = 10'(h);
      vif.v_count  = 10'(v);
      vif.hsync_in = hs;
      vif.vsync_in = (v >= 490 && v < 492) ? 1'b0 : 1'b1;
      vif.mode_req = req;
      vif.mode_sel = sel;
      vif.pix_en   = 1'b1;
      @(negedge clk);
      vif.pix_en   = 1'b0;
      vif.mode_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // after show(h,v) the outputs carry pixel (h,v)
   task automatic show(input int h, input int v);
      tick(h, v, 1'b1, 1'b0, 2'd0);
      tick(h + 1, v, 1'b1, 1'b0, 2'd0);
   endtask

   task automatic frame();
      tick(0, 0, 1'b1, 1'b0, 2'd0);
      exp_fc = (exp_fc + 1) % 256;
   endtask

   task automatic req(input logic [1:0] sel);
      @(negedge clk);
      vif.mode_sel = sel;
      vif.mode_req = 1'b1;
      @(negedge clk);
      vif.mode_req = 1'b0;
   endtask

   initial begin
      int lows, first_low, last_low, vis, hs_act;
      vif.pix_en   = 1'b0;
      vif.h_count  = '0;
      vif.v_count  = '0;
      vif.hsync_in = 1'b1;
      vif.vsync_in = 1'b1;
      vif.mode_sel = 2'd0;
      vif.mode_req = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rgb", rgb(), 32'h000);
      check("reset_active", 32'(vif.active_out), 32'd0);
      check("reset_hsync", 32'(vif.hsync_out), 32'd1);
      check("reset_vsync", 32'(vif.vsync_out), 32'd1);
      check("reset_mode", 32'(vif.mode_cur), 32'd0);
      check("reset_fc", 32'(vif.frame_count), 32'd0);
      reset = 1'b0;

      frame();
      check("lat1_active", 32'(vif.active_out), 32'd0);
      check("fc_first_frame", 32'(vif.frame_count), 32'd1);
      tick(1, 0, 1'b1, 1'b0, 2'd0);
      check("px0_rgb", rgb(), 32'h000);
      check("px0_active", 32'(vif.active_out), 32'd1);
      show(79, 0);   check("bar_h79", rgb(), 32'h000);
      show(80, 0);   check("bar_h80", rgb(), 32'h00F);
      show(240, 0);  check("bar_h240", rgb(), 32'h0FF);
      show(560, 0);  check("bar_h560", rgb(), 32'hFFF);
      show(640, 0);  check("bar_h640_rgb", rgb(), 32'h000);
      check("bar_h640_active", 32'(vif.active_out), 32'd0);
      show(639, 479); check("bar_corner_rgb", rgb(), 32'hFFF);
      show(639, 480); check("bar_v480_active", 32'(vif.active_out), 32'd0);

      lows = 0; first_low = -1; last_low = -1; vis = 0; hs_act = 0;
      for (int h = 600; h <= 800; h++) begin
         tick(h, 0, (h >= 656 && h <= 751) ? 1'b0 : 1'b1, 1'b0, 2'd0);
         if (h > 600) begin
            if (vif.active_out) vis++;
            if (!vif.hsync_out) begin
               lows++;
               if (first_low < 0) first_low = h - 1;
               last_low = h - 1;
               if (vif.active_out || rgb() != 32'h000) hs_act++;
            end
         end
      end
      check("hsync_low_count", 32'(lows), 32'd96);
      check("hsync_first", 32'(first_low), 32'd656);
      check("hsync_last", 32'(last_low), 32'd751);
      check("hsync_visible_pixels", 32'(vis), 32'd40);
      check("hsync_colour_overlap", 32'(hs_act), 32'd0);
      show(0, 490);  check("vsync_low", 32'(vif.vsync_out), 32'd0);
      show(0, 489);  check("vsync_high", 32'(vif.vsync_out), 32'd1);

      tick(100, 200, 1'b1, 1'b0, 2'd0);
      req(2'd1);
      tick(300, 200, 1'b1, 1'b0, 2'd0);
      req(2'd2);
      check("mode_hold_a", 32'(vif.mode_cur), 32'd0);
      show(560, 200); check("mode_hold_rgb", rgb(), 32'hFFF);
      check("mode_hold_b", 32'(vif.mode_cur), 32'd0);
      frame();
      check("mode_apply_2", 32'(vif.mode_cur), 32'd2);
      tick(1, 0, 1'b1, 1'b0, 2'd0);
      check("grad_first_px", rgb(), 32'h002);
      show(576, 300); check("grad_576_300", rgb(), 32'h992);

      req(2'd1);
      frame();
      check("mode_apply_1", 32'(vif.mode_cur), 32'd1);
      show(32, 0);   check("chk_32_0", rgb(), 32'hFFF);
      show(32, 32);  check("chk_32_32", rgb(), 32'h000);
      show(31, 0);   check("chk_31_0", rgb(), 32'h000);

      req(2'd3);
      while (exp_fc < 10) frame();
      check("fc_10", 32'(vif.frame_count), 32'd10);
      check("mode_apply_3", 32'(vif.mode_cur), 32'd3);
      show(20, 224); check("box_20_224", rgb(), 32'hFFF);
      show(52, 224); check("box_52_224", rgb(), 32'h00F);
      show(20, 256); check("box_20_256", rgb(), 32'h00F);
      show(51, 255); check("box_51_255", rgb(), 32'hFFF);
      show(19, 224); check("box_19_224", rgb(), 32'h00F);

      while (exp_fc < 255) frame();
      check("fc_255", 32'(vif.frame_count), 32'd255);
      show(530, 224); check("box_fc255_in", rgb(), 32'hFFF);
      show(600, 224); check("box_fc255_out", rgb(), 32'h00F);
      frame();
      check("fc_wrap", 32'(vif.frame_count), 32'd0);

      tick(0, 0, 1'b1, 1'b1, 2'd1);
      exp_fc = exp_fc + 1;
      check("coinc_fc", 32'(vif.frame_count), 32'(exp_fc));
      check("coinc_mode_hold", 32'(vif.mode_cur), 32'd3);
      tick(1, 0, 1'b1, 1'b0, 2'd0);
      check("coinc_px0_rgb", rgb(), 32'h00F);
      frame();
      check("coinc_mode_next", 32'(vif.mode_cur), 32'd1);

      tick(320, 240, 1'b1, 1'b0, 2'd0);
      tick(321, 240, 1'b1, 1'b0, 2'd0);
      check("pre_reset_rgb", rgb(), 32'hFFF);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_reset_rgb", rgb(), 32'h000);
      check("mid_reset_active", 32'(vif.active_out), 32'd0);
      check("mid_reset_hsync", 32'(vif.hsync_out), 32'd1);
      check("mid_reset_vsync", 32'(vif.vsync_out), 32'd1);
      check("mid_reset_mode", 32'(vif.mode_cur), 32'd0);
      check("mid_reset_fc", 32'(vif.frame_count), 32'd0);
      tick(322, 240, 1'b1, 1'b0, 2'd0);
      check("post_reset_lat1", 32'(vif.active_out), 32'd0);
      tick(323, 240, 1'b1, 1'b0, 2'd0);
      check("post_reset_rgb", rgb(), 32'hF00);
      check("post_reset_active", 32'(vif.active_out), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
